mem_bus_master: RTL and testbench
=================================

# mem_bus_master

Bus initiator for `memory_unit`. It accepts single read, single write, block fill and block copy requests from the CPU datapath over a valid/ready handshake. It sequences the `we`/`int_abus`/`int_wbus` bus cycles and samples `int_rbus`. It sits between the control unit and `memory_unit`, and is the only driver of the memory bus.

## Interface
- `WIDTH`, 16, data and address width; must match `memory_unit`.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high. Returns every register to its reset value immediately.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: high exactly when the state is IDLE. A request is accepted on a rising edge where `req_valid & req_ready`.
- `req_op` in 2: 00 READ, 01 WRITE, 10 FILL, 11 COPY.
- `req_addr` in WIDTH: READ/WRITE/FILL target address; COPY source address.
- `req_data` in WIDTH: WRITE/FILL value; COPY destination address.
- `req_len` in WIDTH: word count for FILL/COPY. Ignored (treated as 1) for READ/WRITE.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out WIDTH: READ data; WRITE/FILL value; last word copied for COPY. Holds until the next completion.
- `rsp_count` out WIDTH: words transferred by the completed request.
- `busy` out 1: state != IDLE.
- `we` out 1: memory write enable.
- `int_abus` out WIDTH: memory address.
- `int_wbus` out WIDTH: memory write data.
- `int_rbus` in WIDTH: memory read data. Valid after the edge that sampled `int_abus`.

## Operation
- All outputs except `req_ready`/`busy` are registered.
- Reset values: `we`=0, `int_abus`=0, `int_wbus`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_count`=0, state IDLE (`req_ready`=1, `busy`=0).
- States:
  - IDLE
  - RD_ADDR: address driven, `we`=0.
  - RD_DATA: `int_rbus` is captured on this state's edge.
  - WR: `we`=1 with address and data driven.
- READ: IDLE → RD_ADDR → RD_DATA → IDLE. `rsp_data` ← `int_rbus`.
- WRITE: IDLE → WR → IDLE.
- FILL: WR repeats for `req_len` cycles. `int_abus` increments by 1 per write, `int_wbus` is constant, and `we` stays 1 throughout.
- COPY, per word: RD_ADDR (src+i) → RD_DATA (capture; `int_abus`←dst+i, `int_wbus`←`int_rbus`) → WR. After WR, go to RD_ADDR (src+i+1), or to IDLE after the last word.
- Internal registers: source pointer, destination pointer, remaining count, transferred count. Pointers wrap modulo 2^WIDTH (0xFFFF → 0x0000) with no error.
- FILL/COPY with `req_len`=0: no bus cycle. Set `rsp_valid`, `rsp_count`=0 and stay in IDLE; `rsp_data` is unchanged.
- `req_valid` while `busy` is ignored. There is no queueing; the requester holds its request.
- Memory-mapped locations (0xFFB PSW, 0xFFC–0xFFF ports) get no special treatment. Each location is accessed exactly once per word, so a COPY from portb (0xFFD) samples it once.
- On leaving WR into IDLE, `we` returns to 0 in the same edge.

## Timing
- Accept edge E0 drives the first bus cycle: outputs are valid in the cycle after E0.
- READ: memory samples at E1; capture at E2; `rsp_valid` high in the cycle after E2.
- WRITE: memory writes at E1; `rsp_valid` high after E1, with `we` low in that same cycle.
- FILL length N: writes at E1..EN; `rsp_valid` after EN.
- COPY length N: 3 cycles per word; final write at E(3N); `rsp_valid` after E(3N).
- `req_ready` returns high in the same cycle as `rsp_valid`, so back-to-back acceptance on the next edge is allowed.
- Reset mid-operation: `we` drops asynchronously and no further bus cycles occur. Words already written stay written, and no `rsp_valid` is issued.

## Structure
- Shared package `mem_bus_pkg` holds:
  - op encodings
  - state encodings
  - MMIO address constants: PSW 0xFFB, PORTA 0xFFC, PORTB 0xFFD, PORTC 0xFFE, PORTD 0xFFF
- Single module; no sub-module is warranted. The pointer/count logic stays inline.

## Test plan
Pair the block with `memory_unit`; memory words 0..3 are preloaded with the values 0..3.
- Reset, then READ 0x0002 → `we` never asserts, `int_abus`=0x0002, and `rsp_valid` appears 2 cycles after acceptance with `rsp_data`=0x0002 and `rsp_count`=1.
- WRITE 0x0010 ← 0xBEEF → `we`=1 for exactly one cycle with `int_abus`=0x0010 and `int_wbus`=0xBEEF. `rsp_valid` follows. A subsequent READ 0x0010 returns 0xBEEF.
- FILL addr 0x0020, len 4, value 0x00AA → four consecutive `we` cycles at 0x20..0x23, then `rsp_count`=4. READs of 0x20..0x23 return 0x00AA.
- COPY src 0x0000, dst 0x0040, len 4 → 12 busy cycles; 0x40..0x43 read back 0..3; `rsp_data`=0x0003, `rsp_count`=4.
- WRITE 0x0FFC ← 0x00FF → `porta`=0x00FF. Then COPY src 0x0FFD, dst 0x0050, len 1 with `portb`=0x00DD → 0x0050 reads 0x00DD.
- Edge cases, run in sequence:
  - FILL 0x0060, len 0 → `rsp_valid` in the cycle after acceptance, no `we`.
  - FILL 0x0070, len 8, with `reset` pulsed after the second write → `we` drops immediately and only 0x70–0x71 change.
  - `req_valid` held while busy is not accepted until `req_ready`=1.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory bus initiator: request ops, FSM states
// and the memory-mapped I/O addresses of memory_unit.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_COPY  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_ADDR = 2'b01,
    ST_RD_DATA = 2'b10,
    ST_WR      = 2'b11
  } state_e;

  localparam logic [15:0] ADDR_PSW   = 16'h0FFB;
  localparam logic [15:0] ADDR_PORTA = 16'h0FFC;
  localparam logic [15:0] ADDR_PORTB = 16'h0FFD;
  localparam logic [15:0] ADDR_PORTC = 16'h0FFE;
  localparam logic [15:0] ADDR_PORTD = 16'h0FFF;

endpackage

// File: rtl/mem_bus_master.sv
// Sole initiator of the memory_unit bus: sequences single read/write,
// block fill and block copy requests into registered we/abus/wbus cycles.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] req_len,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] rsp_count,
  output logic             busy,
  output logic             we,
  output logic [WIDTH-1:0] int_abus,
  output logic [WIDTH-1:0] int_wbus,
  input  logic [WIDTH-1:0] int_rbus
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d, cnt_q, cnt_d;
  logic             we_q, we_d, rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] abus_q, abus_d, wbus_q, wbus_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d, rsp_count_q, rsp_count_d;

  op_e  req_op_e;
  logic accept, blk_op, zero_len, last_word;

  assign req_op_e  = op_e'(req_op);
  assign accept    = req_valid && (state_q == ST_IDLE);
  assign blk_op    = (req_op_e == OP_FILL) || (req_op_e == OP_COPY);
  assign zero_len  = blk_op && (req_len == '0);
  assign last_word = (rem_q == WIDTH'(1));

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign we        = we_q;
  assign int_abus  = abus_q;
  assign int_wbus  = wbus_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_count = rsp_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !zero_len) begin
          unique case (req_op_e)
            OP_READ, OP_COPY:  state_d = ST_RD_ADDR;
            OP_WRITE, OP_FILL: state_d = ST_WR;
          endcase
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = (op_q == OP_READ) ? ST_IDLE : ST_WR;
      ST_WR: begin
        if (last_word)             state_d = ST_IDLE;
        else if (op_q == OP_FILL)  state_d = ST_WR;
        else                       state_d = ST_RD_ADDR;
      end
    endcase
  end

  always_comb begin
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    abus_d      = abus_q;
    wbus_d      = wbus_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_count_d = rsp_count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (zero_len) begin
            // Empty block: report immediately, leave the bus untouched.
            rsp_valid_d = 1'b1;
            rsp_count_d = '0;
          end else begin
            op_d   = req_op_e;
            cnt_d  = '0;
            rem_d  = blk_op ? req_len : WIDTH'(1);
            src_d  = req_addr + WIDTH'(1);
            dst_d  = req_data;
            abus_d = req_addr;
            wbus_d = req_data;
            we_d   = (req_op_e == OP_WRITE) || (req_op_e == OP_FILL);
          end
        end
      end
      ST_RD_ADDR: ;
      ST_RD_DATA: begin
        if (op_q == OP_READ) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = int_rbus;
          rsp_count_d = WIDTH'(1);
        end else begin
          abus_d = dst_q;
          wbus_d = int_rbus;
          dst_d  = dst_q + WIDTH'(1);
          we_d   = 1'b1;
        end
      end
      ST_WR: begin
        cnt_d = cnt_q + WIDTH'(1);
        rem_d = rem_q - WIDTH'(1);
        if (last_word) begin
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = wbus_q;
          rsp_count_d = cnt_q + WIDTH'(1);
        end else if (op_q == OP_FILL) begin
          abus_d = abus_q + WIDTH'(1);
        end else begin
          we_d   = 1'b0;
          abus_d = src_q;
          src_d  = src_q + WIDTH'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_READ;
      src_q       <= '0;
      dst_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      abus_q      <= '0;
      wbus_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_count_q <= '0;
    end else begin
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      abus_q      <= abus_d;
      wbus_q      <= wbus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_count_q <= rsp_count_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench: mem_bus_master paired with a small synchronous memory
// model carrying porta (write) and portb (read) at their mapped addresses.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_data, req_len;
  logic        rsp_valid, busy, we;
  logic [15:0] rsp_data, rsp_count, int_abus, int_wbus, int_rbus;

  logic [15:0] mem [0:65535];
  logic [15:0] porta, portb;

  int tests = 0, fails = 0;
  int lat, busy_cyc, we_cyc;
  logic [15:0] we_min, we_max, first_abus, first_wbus;

  always #5 clk = ~clk;

  mem_bus_master #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_count(rsp_count),
    .busy(busy), .we(we), .int_abus(int_abus), .int_wbus(int_wbus),
    .int_rbus(int_rbus)
  );

  always @(posedge clk) begin
    if (we) begin
      if (int_abus == 16'h0FFC) porta <= int_wbus;
      else                      mem[int_abus] <= int_wbus;
    end
    int_rbus <= (int_abus == 16'h0FFD) ? portb : mem[int_abus];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample at falling edges until the completion pulse; lat counts edges after accept.
  task automatic wait_rsp();
    bit got = 0;
    lat = 0; busy_cyc = 0; we_cyc = 0; we_min = 16'hFFFF; we_max = 16'h0000;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (i == 0) begin first_abus = int_abus; first_wbus = int_wbus; end
      if (busy) busy_cyc++;
      if (we) begin
        we_cyc++;
        if (int_abus < we_min) we_min = int_abus;
        if (int_abus > we_max) we_max = int_abus;
      end
      if (rsp_valid) begin got = 1; break; end
      lat++;
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] l);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d; req_len = l;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp();
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    run_req(2'b00, a, 16'h0, 16'h0);
    chk(tag, {16'h0, rsp_data}, {16'h0, exp});
  endtask

  initial begin
    int rv;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 4; i++) mem[i] = 16'(i);
    porta = 16'h0; portb = 16'h0; int_rbus = 16'h0;
    req_valid = 1'b0; req_op = 2'b00; req_addr = 16'h0; req_data = 16'h0; req_len = 16'h0;
    reset = 1'b1;
    #1;
    chk("rst_we", {31'h0, we}, 32'd0);
    chk("rst_abus", {16'h0, int_abus}, 32'd0);
    chk("rst_wbus", {16'h0, int_wbus}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'h0, rsp_data}, 32'd0);
    chk("rst_rsp_count", {16'h0, rsp_count}, 32'd0);
    chk("rst_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // READ 0x0002
    run_req(2'b00, 16'h0002, 16'h0, 16'h0);
    chk("rd_we", we_cyc, 32'd0);
    chk("rd_abus", {16'h0, first_abus}, 32'h0002);
    chk("rd_lat", lat, 32'd2);
    chk("rd_data", {16'h0, rsp_data}, 32'h0002);
    chk("rd_count", {16'h0, rsp_count}, 32'd1);

    // WRITE 0x0010 <- 0xBEEF
    run_req(2'b01, 16'h0010, 16'hBEEF, 16'h0);
    chk("wr_we_cyc", we_cyc, 32'd1);
    chk("wr_abus", {16'h0, first_abus}, 32'h0010);
    chk("wr_wbus", {16'h0, first_wbus}, 32'hBEEF);
    chk("wr_lat", lat, 32'd1);
    chk("wr_count", {16'h0, rsp_count}, 32'd1);
    rd_chk("wr_readback", 16'h0010, 16'hBEEF);

    // FILL 0x20..0x23 with 0x00AA
    run_req(2'b10, 16'h0020, 16'h00AA, 16'd4);
    chk("fill_we_cyc", we_cyc, 32'd4);
    chk("fill_min", {16'h0, we_min}, 32'h0020);
    chk("fill_max", {16'h0, we_max}, 32'h0023);
    chk("fill_wbus", {16'h0, first_wbus}, 32'h00AA);
    chk("fill_lat", lat, 32'd4);
    chk("fill_count", {16'h0, rsp_count}, 32'd4);
    for (int i = 0; i < 4; i++) rd_chk("fill_readback", 16'h0020 + 16'(i), 16'h00AA);

    // COPY 0x0..0x3 -> 0x40..0x43
    run_req(2'b11, 16'h0000, 16'h0040, 16'd4);
    chk("copy_busy", busy_cyc, 32'd12);
    chk("copy_lat", lat, 32'd12);
    chk("copy_we_cyc", we_cyc, 32'd4);
    chk("copy_data", {16'h0, rsp_data}, 32'h0003);
    chk("copy_count", {16'h0, rsp_count}, 32'd4);
    for (int i = 0; i < 4; i++) rd_chk("copy_readback", 16'h0040 + 16'(i), 16'(i));

    // Port accesses
    run_req(2'b01, 16'h0FFC, 16'h00FF, 16'h0);
    chk("porta", {16'h0, porta}, 32'h00FF);
    portb = 16'h00DD;
    run_req(2'b11, 16'h0FFD, 16'h0050, 16'd1);
    chk("portb_lat", lat, 32'd3);
    rd_chk("portb_copy", 16'h0050, 16'h00DD);

    // Zero-length FILL: immediate completion, no bus write, data held
    run_req(2'b10, 16'h0060, 16'h1111, 16'd0);
    chk("len0_lat", lat, 32'd0);
    chk("len0_we", we_cyc, 32'd0);
    chk("len0_busy", busy_cyc, 32'd0);
    chk("len0_count", {16'h0, rsp_count}, 32'd0);
    chk("len0_data", {16'h0, rsp_data}, 32'h00DD);
    chk("len0_mem", {16'h0, mem[16'h0060]}, 32'h0000);

    // Reset after the second of eight fill writes
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 16'h0070; req_data = 16'h0055; req_len = 16'd8;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_we", {31'h0, we}, 32'd0);
    chk("mid_rst_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid || we) rv++;
    end
    chk("mid_rst_quiet", rv, 32'd0);
    chk("mid_rst_m70", {16'h0, mem[16'h0070]}, 32'h0055);
    chk("mid_rst_m71", {16'h0, mem[16'h0071]}, 32'h0055);
    chk("mid_rst_m72", {16'h0, mem[16'h0072]}, 32'h0000);
    chk("mid_rst_m77", {16'h0, mem[16'h0077]}, 32'h0000);

    // Request held during a busy FILL must wait for req_ready
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 16'h0080; req_data = 16'h1234; req_len = 16'd3;
    @(posedge clk);
    #1 req_op = 2'b00; req_addr = 16'h0081;
    wait_rsp();
    chk("hold_fill_we", we_cyc, 32'd3);
    chk("hold_fill_count", {16'h0, rsp_count}, 32'd3);
    chk("hold_ready", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp();
    chk("hold_rd_lat", lat, 32'd2);
    chk("hold_rd_data", {16'h0, rsp_data}, 32'h1234);

    // Address wrap on FILL
    run_req(2'b10, 16'hFFFF, 16'h0077, 16'd2);
    chk("wrap_ffff", {16'h0, mem[16'hFFFF]}, 32'h0077);
    chk("wrap_0000", {16'h0, mem[16'h0000]}, 32'h0077);
    chk("wrap_0001", {16'h0, mem[16'h0001]}, 32'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
